sp_sram_param: RTL
==================

Name: sp_sram_param

Overview:
- Parametrised single-port synchronous SRAM replacing the fixed 11x16 coefficient store in the FIR datapath.
- Adds configurable width and depth, a registered read-valid flag and a sticky address-range error flag.
- Adds a sequential clear engine that zeroes one word per cycle, so the array stays inferable as RAM with no parallel reset.
- Sits between the FIR controller (coefficient load and readout) and the MAC datapath.

Parameters:
- DW, 16, data word width in bits.
- DEPTH, 11, number of words; legal addresses are 0..DEPTH-1.
- AW, 4, address width; DEPTH <= 2**AW is required, otherwise elaboration fails.

Ports:
- iClk12M  in  1  system clock; all logic on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iCsnRam  in  1  chip select, active-low.
- iWrnRam  in  1  0 = write, 1 = read; qualified by iCsnRam=0.
- iAddrRam  in  AW  word address.
- iWtDtRam  in  DW  write data.
- iClrReq  in  1  single-cycle request to zero the whole array.
- iErrClr  in  1  clears oAddrErr.
- oRdDtRam  out  DW  read data, registered.
- oRdVld  out  1  one-cycle pulse, aligned with new oRdDtRam.
- oBusy  out  1  high while the clear engine runs.
- oAddrErr  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (iRst=1 at an edge):
  - state <= CLEAR, clear counter <= 0.
  - oRdDtRam <= 0, oRdVld <= 0, oAddrErr <= 0.
  - Array contents are not reset directly.
  - oBusy = (state==CLEAR), so oBusy reads 1 after reset.
  - Reset mid-clear or mid-access restarts the clear from word 0.
- FSM states:
  - CLEAR:
    - Each edge writes 0 to mem[cnt], then cnt <= cnt+1.
    - At cnt==DEPTH-1: final write, then state <= IDLE and cnt <= 0.
    - oBusy stays high for exactly DEPTH edges after iRst falls.
  - IDLE:
    - iClrReq=1 causes state <= CLEAR, cnt <= 0.
    - An access in the same cycle as iClrReq is dropped: clear wins.
- Accesses while in CLEAR:
  - Ignored: no write, oRdVld=0, oAddrErr unchanged.
  - iClrReq during CLEAR is ignored; the clear does not restart.
- Write (IDLE, iCsnRam=0, iWrnRam=0):
  - addr<DEPTH: mem[addr] <= iWtDtRam at the edge.
  - addr>=DEPTH: no write, oAddrErr <= 1.
  - oRdVld=0, oRdDtRam holds.
- Read (IDLE, iCsnRam=0, iWrnRam=1):
  - Latency 1: at the edge, oRdDtRam <= mem[addr] and oRdVld <= 1 for one cycle.
  - addr>=DEPTH: oRdDtRam <= 0, oRdVld <= 1, oAddrErr <= 1.
- No access or iCsnRam=1: oRdVld <= 0, oRdDtRam holds its last value.
- Write followed by read of the same address on the next cycle returns the newly written data.
- oAddrErr:
  - Set only by an out-of-range access in IDLE.
  - Cleared by iErrClr=1.
  - Set and clear in the same cycle: set wins.
- Unused address values (DEPTH..2**AW-1) never alias onto valid words.

Optional Feature:
- Macro: SP_SRAM_RDREG_EN.
- Defined:
  - Adds a second output register stage; read latency becomes 2 edges.
  - oRdVld is delayed to stay aligned with the data.
  - Both stages reset to 0.
  - Entering CLEAR flushes an in-flight read: its oRdVld is suppressed and the data stage holds.
  - Back-to-back reads stream one per cycle.
- Undefined: latency 1 as specified above; no extra flops.

Test Plan:
- Reset and clear: assert iRst 2 cycles, then release.
  - oBusy=1 for exactly 11 edges, then 0.
  - Reads of all addresses 0..10 return 0x0000 with oRdVld pulsed each cycle.
- Write/read: write 0x1234 @3, 0xBEEF @10, 0xFFFF @0; then read 3, 10, 0 back-to-back.
  - oRdDtRam = 0x1234, 0xBEEF, 0xFFFF on consecutive cycles, oRdVld=1 throughout, oAddrErr=0.
- Range error: write 0x5555 @0xB, then read @0xF.
  - No array word changes; read returns 0x0000 with oRdVld=1; oAddrErr=1 and stays set.
  - Pulse iErrClr: oAddrErr=0.
  - iErrClr coincident with another @0xC access: oAddrErr stays 1.
- Clear request: fill all words with 0xA5A5, pulse iClrReq alongside a write of 0x1111 @2.
  - oBusy high 11 cycles; reads issued during busy give oRdVld=0.
  - Afterwards every word reads 0x0000, including @2.
- Reset mid-clear: assert iRst at clear cycle 5.
  - Clear restarts; oBusy high 11 more edges after release; oRdDtRam=0.
- Parameter sweep: DW=24, DEPTH=16, AW=4.
  - Write 0xABCDEF @15, read @15 returns 0xABCDEF; no address is out-of-range.
  - With SP_SRAM_RDREG_EN defined, oRdVld and data appear 2 edges after the read request.

Source files
------------

// File: rtl/sp_sram_param.sv
// Parametrised single-port coefficient SRAM with sequential clear engine.
// Define SP_SRAM_RDREG_EN for a second read output register (latency 2).
module sp_sram_param #(
  parameter int DW    = 16,
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input  logic          iClk12M,
  input  logic          iRst,
  input  logic          iCsnRam,
  input  logic          iWrnRam,
  input  logic [AW-1:0] iAddrRam,
  input  logic [DW-1:0] iWtDtRam,
  input  logic          iClrReq,
  input  logic          iErrClr,
  output logic [DW-1:0] oRdDtRam,
  output logic          oRdVld,
  output logic          oBusy,
  output logic          oAddrErr
);

  generate
    if (DEPTH > (1 << AW)) begin : gBadDepth
      $error("sp_sram_param: DEPTH exceeds 2**AW");
    end
  endgenerate

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);
  localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   nextCnt;
  logic [DW-1:0]   mem [DEPTH];

  logic            memWe;
  logic [AW-1:0]   memWa;
  logic [DW-1:0]   memWd;
  logic            rdEn;
  logic            errSet;
  logic            inRange;
  logic [DW-1:0]   rdData;

  logic [DW-1:0]   rdDt1;
  logic            rdVld1;

  assign inRange = {1'b0, iAddrRam} < DepthW;
  assign rdData  = inRange ? mem[iAddrRam] : '0;
  assign oBusy   = (state == CLEAR);

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    memWe     = 1'b0;
    memWa     = iAddrRam;
    memWd     = iWtDtRam;
    rdEn      = 1'b0;
    errSet    = 1'b0;
    unique case (state)
      CLEAR: begin
        memWe = 1'b1;
        memWa = cnt;
        memWd = '0;
        if (cnt == LastIdx) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + 1'b1;
        end
      end
      IDLE: begin
        // A clear request pre-empts any access in the same cycle.
        priority case (1'b1)
          iClrReq: begin
            nextState = CLEAR;
            nextCnt   = '0;
          end
          !iCsnRam: begin
            rdEn   = iWrnRam;
            errSet = !inRange;
            memWe  = inRange && !iWrnRam;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge iClk12M) begin
    if (memWe && !iRst)
      mem[memWa] <= memWd;
  end

  always_ff @(posedge iClk12M) begin
    if (iRst)
      oAddrErr <= 1'b0;
    else if (errSet)
      oAddrErr <= 1'b1;
    else if (iErrClr)
      oAddrErr <= 1'b0;
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      rdDt1  <= '0;
      rdVld1 <= 1'b0;
    end else begin
      rdVld1 <= rdEn;
      if (rdEn)
        rdDt1 <= rdData;
    end
  end

`ifdef SP_SRAM_RDREG_EN
  logic flush;
  logic [DW-1:0] rdDt2;
  logic          rdVld2;

  assign flush = (state == IDLE) && iClrReq;

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      rdDt2  <= '0;
      rdVld2 <= 1'b0;
    end else begin
      rdVld2 <= rdVld1 && !flush;
      if (rdVld1 && !flush)
        rdDt2 <= rdDt1;
    end
  end

  assign oRdDtRam = rdDt2;
  assign oRdVld   = rdVld2;
`else
  assign oRdDtRam = rdDt1;
  assign oRdVld   = rdVld1;
`endif

endmodule
